neuron_mac_sequencer: RTL and testbench

//  Consumer of one per-neuron weight BRAM (16-bit words, N_IN entries, read on negedge CLK).
//  On START it walks addresses 0..N_IN-1, driving the weight BRAM and the input-activation

---
 rtl/neuron_mac_sequencer.sv | 148 ++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron multiply-accumulate sequencer: walks a weight BRAM and input buffer in lockstep,
// accumulates W*X onto a scaled bias, then rescales, applies optional ReLU and saturates to 16 bits.
module neuron_mac_sequencer #(
    parameter int N_IN   = 28,
    parameter int ADDR_W = 5,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int RELU   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [15:0]       BIAS,
    output logic [ADDR_W-1:0] ADDR,
    output logic              EN,
    output logic              WE,
    input  logic [15:0]       W_DO,
    input  logic [15:0]       X_DO,
    output logic [15:0]       Y,
    output logic              Y_VALID,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0]  SAT_MIN   = ACC_W'(-32768);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     en_q, en_d;
    logic                     busy_q, busy_d;
    logic                     yv_q, yv_d;
    logic [15:0]              y_q, y_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [31:0]       prod_q, prod_d;
    logic                     pv_q, pv_d;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  clipped;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            yv_q    <= 1'b0;
            y_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            yv_q    <= yv_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
        end
    end

    // ReLU is applied to the rescaled accumulator before clamping to the 16-bit range.
    always_comb begin
        shifted = acc_q >>> FRAC;
        clipped = shifted;
        if (RELU != 0 && shifted[ACC_W-1]) begin
            clipped = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = en_q;
        busy_d  = busy_q;
        yv_d    = 1'b0;
        y_d     = y_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        // Memory data seen while in FETCH belongs to the previous cycle's address.
        pv_d    = (state_q == S_FETCH);

        if (state_q == S_FETCH) begin
            prod_d = $signed(W_DO) * $signed(X_DO);
        end
        if (pv_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
        if (yv_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (START && !busy_q) begin
                    state_d = S_FETCH;
                    en_d    = 1'b1;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    acc_d   = ACC_W'($signed(BIAS)) <<< FRAC;
                end
            end
            S_FETCH: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    en_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                yv_d    = 1'b1;
                state_d = S_IDLE;
                if (clipped > SAT_MAX) begin
                    y_d = 16'h7FFF;
                end else if (clipped < SAT_MIN) begin
                    y_d = 16'h8000;
                end else begin
                    y_d = clipped[15:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ADDR    = addr_q;
    assign EN      = en_q;
    assign WE      = 1'b0;
    assign Y       = y_q;
    assign Y_VALID = yv_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: RELU=1 and RELU=0 instances share one memory model and are
// checked against a plain-arithmetic neuron reference over directed and random runs.
module tb_neuron_mac_sequencer;

    localparam int N_IN   = 28;
    localparam int ADDR_W = 5;
    localparam int FRAC   = 8;
    localparam int ACC_W  = 40;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic [15:0]       BIAS = '0;
    logic [15:0]       w_do = '0;
    logic [15:0]       x_do = '0;

    logic [ADDR_W-1:0] r_addr, l_addr;
    logic              r_en, l_en, r_we, l_we;
    logic [15:0]       r_y, l_y;
    logic              r_yv, l_yv, r_busy, l_busy;

    logic [15:0]       w_mem [N_IN];
    logic [15:0]       x_mem [N_IN];

    int n_cmp = 0;
    int n_bad = 0;

    neuron_mac_sequencer #(.N_IN(N_IN), .ADDR_W(ADDR_W), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(1)) u_relu (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BIAS(BIAS),
        .ADDR(r_addr), .EN(r_en), .WE(r_we), .W_DO(w_do), .X_DO(x_do),
        .Y(r_y), .Y_VALID(r_yv), .BUSY(r_busy)
    );

    neuron_mac_sequencer #(.N_IN(N_IN), .ADDR_W(ADDR_W), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(0)) u_lin (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BIAS(BIAS),
        .ADDR(l_addr), .EN(l_en), .WE(l_we), .W_DO(w_do), .X_DO(x_do),
        .Y(l_y), .Y_VALID(l_yv), .BUSY(l_busy)
    );

    always #5 CLK = ~CLK;

    // Both memories answer on the negedge following the registered address.
    always @(negedge CLK) begin
        if (r_en) begin
            w_do <= w_mem[r_addr];
            x_do <= x_mem[r_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input logic [15:0] b, input bit relu);
        longint acc;
        longint s;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < N_IN; i++) begin
            acc += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
        end
        s = acc >>> FRAC;
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < N_IN; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_addr"}, 32'(r_addr), 32'd0);
        check({tag, "_en"},   32'(r_en),   32'd0);
        check({tag, "_we"},   32'(r_we | l_we), 32'd0);
        check({tag, "_y"},    32'(r_y | l_y), 32'd0);
        check({tag, "_yv"},   32'(r_yv | l_yv), 32'd0);
        check({tag, "_busy"}, 32'(r_busy | l_busy), 32'd0);
    endtask

    // mode 0: plain run; 1: stray STARTs + BIAS change mid-run; 2: reset abort at cycle 12;
    // 3: plain run ending with a back-to-back START. pre=1: START already accepted by caller.
    task automatic do_run(input string tag, input logic [15:0] b, input int mode, input bit pre);
        logic [15:0] exp_r, exp_l;
        bit          seen;
        exp_r = ref_y(b, 1'b1);
        exp_l = ref_y(b, 1'b0);
        if (!pre) begin
            BIAS  = b;
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        check({tag, "_p0_addr"}, 32'(r_addr), 32'd0);
        check({tag, "_p0_en"},   32'(r_en),   32'd1);
        check({tag, "_p0_busy"}, 32'(r_busy), 32'd1);
        for (int k = 1; k <= N_IN + 4; k++) begin
            @(posedge CLK);
            #1;
            if (mode == 2 && k == 12) begin
                RST_N = 1'b0;
                #1;
                check_idle_reset({tag, "_abort"});
                repeat (2) @(posedge CLK);
                #1;
                RST_N = 1'b1;
                seen = 1'b0;
                repeat (N_IN + 6) begin
                    @(posedge CLK);
                    #1;
                    seen |= r_yv | l_yv;
                end
                check({tag, "_no_yv"}, 32'(seen), 32'd0);
                return;
            end
            if (k < N_IN) begin
                check($sformatf("%s_addr%0d", tag, k), 32'(r_addr), 32'(k));
                check($sformatf("%s_en%0d", tag, k), 32'(r_en), 32'd1);
            end else if (k == N_IN) begin
                check({tag, "_end_addr"}, 32'(r_addr), 32'd0);
                check({tag, "_end_en"},   32'(r_en),   32'd0);
            end else if (!(mode == 3 && k == N_IN + 4)) begin
                check($sformatf("%s_en_off%0d", tag, k), 32'(r_en), 32'd0);
            end
            check($sformatf("%s_yv%0d", tag, k), 32'(r_yv), 32'(k == N_IN + 2));
            if (k == N_IN + 2) begin
                check({tag, "_y_relu"}, 32'(r_y), 32'(exp_r));
                check({tag, "_y_lin"},  32'(l_y), 32'(exp_l));
                check({tag, "_yv_lin"}, 32'(l_yv), 32'd1);
                check({tag, "_busy_out"}, 32'(r_busy), 32'd1);
            end
            if (k == N_IN + 3) begin
                check({tag, "_busy_done"}, 32'(r_busy), 32'd0);
                check({tag, "_y_hold"},    32'(r_y), 32'(exp_r));
            end
            if (k == N_IN + 4 && mode == 3) begin
                check({tag, "_b2b_en"},   32'(r_en),   32'd1);
                check({tag, "_b2b_busy"}, 32'(r_busy), 32'd1);
                check({tag, "_b2b_addr"}, 32'(r_addr), 32'd0);
            end
            if (mode == 1 && k == 3) BIAS = ~b;
            if (mode == 1) START = (k + 1 == 5) || (k + 1 == 29) || (k + 1 == N_IN + 3);
            else if (mode == 3) START = (k + 1 == N_IN + 4);
            else START = 1'b0;
        end
        START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rb;
        fill(16'h0000, 16'h0000);
        repeat (3) @(posedge CLK);
        #1;
        check_idle_reset("reset");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        fill(16'h0100, 16'h0100);
        do_run("t1", 16'h0000, 0, 1'b0);
        check("t1_const", 32'(r_y), 32'h1C00);

        fill(16'h7FFF, 16'h7FFF);
        do_run("t2pos", 16'h7FFF, 0, 1'b0);
        check("t2_const", 32'(r_y), 32'h7FFF);
        fill(16'h8000, 16'h7FFF);
        do_run("t2neg", 16'h0000, 0, 1'b0);
        check("t2neg_const", 32'(l_y), 32'h8000);

        fill(16'hFF00, 16'h0100);
        do_run("t3", 16'h0500, 0, 1'b0);
        check("t3_relu_const", 32'(r_y), 32'h0000);
        check("t3_lin_const",  32'(l_y), 32'hE900);

        fill(16'h0000, 16'h0000);
        w_mem[0] = 16'h0080;
        x_mem[0] = 16'h0080;
        do_run("t4", 16'hFFFF, 0, 1'b0);
        check("t4_const", 32'(l_y), 32'h003F);

        fill(16'h0100, 16'h0100);
        do_run("t5", 16'h0000, 1, 1'b0);
        BIAS = 16'h0000;
        @(posedge CLK);
        #1;

        do_run("t6", 16'h0000, 2, 1'b0);
        do_run("t6re", 16'h0000, 0, 1'b0);
        check("t6_const", 32'(r_y), 32'h1C00);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (r < 4) begin
                    w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                    x_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                end else begin
                    w_mem[i] = 16'($urandom);
                    x_mem[i] = 16'($urandom);
                end
            end
            rb = 16'($urandom);
            do_run($sformatf("rnd%0d", r), rb, (r == 2) ? 3 : 0, 1'b0);
            if (r == 2) do_run("rnd_b2b", rb, 0, 1'b1);
            @(posedge CLK);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
